// File: rtl/p256_pkg.sv
// Shared constants and types for the word-serial P-256 modular multiplier.
package p256_pkg;

  localparam int WORD_W      = 32;
  localparam int P256_NWORDS = 8;
  localparam logic [255:0] P256_P =
    256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RED_IN = 3'd2,
    MUL    = 3'd3,
    STORE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef enum logic {
    SQUARE   = 1'b0,
    MULTIPLY = 1'b1
  } mode_t;

endpackage

// File: rtl/p256_mod_mul_if.sv
// Operand/result RAM and handshake bundle between the sequencer and p256_mod_mul.
interface p256_mod_mul_if #(
  parameter int AW = 3
) ();

  logic          ena;
  logic          mode;
  logic [31:0]   a_din;
  logic [31:0]   b_din;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [AW-1:0] d_addr;
  logic          d_wren;
  logic [31:0]   d_dout;
  logic          rdy;

  modport master (
    output ena, mode, a_din, b_din,
    input  a_addr, b_addr, d_addr, d_wren, d_dout, rdy
  );

  modport slave (
    input  ena, mode, a_din, b_din,
    output a_addr, b_addr, d_addr, d_wren, d_dout, rdy
  );

endinterface

// File: rtl/p256_mod_mul_step.sv
// One MSB-first interleaved iteration: R' = (2R + bit*A) mod P, given R, A < P.
module p256_mod_mul_step #(
  parameter int W = 256
) (
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] a_i,
  input  logic         bit_i,
  input  logic [W-1:0] mod_i,
  output logic [W-1:0] r_o
);

  logic [W+1:0] t;
  logic         ge_p;
  logic         ge_2p;
  logic [W-1:0] sub;

  // T < 3P, so at most two subtractions; the result fits in W bits and the
  // low W bits of the difference are exact.
  always_comb begin
    t     = {1'b0, r_i, 1'b0} + {2'b00, a_i & {W{bit_i}}};
    ge_2p = t >= {1'b0, mod_i, 1'b0};
    ge_p  = t >= {2'b00, mod_i};
    sub   = ge_2p ? {mod_i[W-2:0], 1'b0} : (ge_p ? mod_i : '0);
    r_o   = t[W-1:0] - sub;
  end

endmodule

// File: rtl/p256_mod_mul.sv
// Word-serial A*B / A^2 mod MODULUS with RAM-fed operands and word-wise write-back.
// Define P256_MOD_MUL_INPUT_REDUCE_EN to pre-reduce inputs below 2*MODULUS.
module p256_mod_mul
  import p256_pkg::*;
#(
  parameter int                        NWORDS  = P256_NWORDS,
  parameter logic [WORD_W*NWORDS-1:0]  MODULUS = P256_P
) (
  input  logic          clk,
  input  logic          rst,
  p256_mod_mul_if.slave bus
);

  localparam int W  = WORD_W * NWORDS;
  localparam int AW = $clog2(NWORDS);
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_LOAD   = LOAD;
`ifdef P256_MOD_MUL_INPUT_REDUCE_EN
  localparam logic [2:0] ST_RED_IN = RED_IN;
`endif
  localparam logic [2:0] ST_MUL    = MUL;
  localparam logic [2:0] ST_STORE  = STORE;
  localparam logic [2:0] ST_DONE   = DONE;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  mode_t         mode_q,  mode_d;
  logic [W-1:0]  a_q,     a_d;
  logic [W-1:0]  b_q,     b_d;
  logic [W-1:0]  r_q,     r_d;
  logic [W-1:0]  r_step;

  p256_mod_mul_step #(.W(W)) u_step (
    .r_i   (r_q),
    .a_i   (a_q),
    .bit_i (b_q[W-1]),
    .mod_i (MODULUS),
    .r_o   (r_step)
  );

  always_comb begin
    // NOTE: every next-state signal starts at its held value so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ena) begin
          mode_d  = mode_t'(bus.mode);
          cnt_d   = '0;
          r_d     = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // RAM data lags the address by one cycle; words shift in from the top so
        // word 0 ends up least significant.
        if (cnt_q != '0) begin
          a_d = {bus.a_din, a_q[W-1:WORD_W]};
          b_d = {(mode_q == MULTIPLY) ? bus.b_din : bus.a_din, b_q[W-1:WORD_W]};
        end
        if (cnt_q == CW'(NWORDS)) begin
          cnt_d = '0;
`ifdef P256_MOD_MUL_INPUT_REDUCE_EN
          state_d = ST_RED_IN;
`else
          state_d = ST_MUL;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef P256_MOD_MUL_INPUT_REDUCE_EN
      ST_RED_IN: begin
        if (cnt_q == '0) begin
          if (a_q >= MODULUS) a_d = a_q - MODULUS;
          cnt_d = CW'(1);
        end else begin
          if (mode_q == SQUARE)     b_d = a_q;
          else if (b_q >= MODULUS)  b_d = b_q - MODULUS;
          cnt_d   = '0;
          state_d = ST_MUL;
        end
      end
`endif
      ST_MUL: begin
        r_d = r_step;
        b_d = {b_q[W-2:0], 1'b0};
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = '0;
          state_d = ST_STORE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STORE: begin
        r_d = {{WORD_W{1'b0}}, r_q[W-1:WORD_W]};
        if (cnt_q == CW'(NWORDS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: operand/result registers are reset too, so an aborted operation leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= SQUARE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
    end
  end

  // Outputs decode only flops, so reset clears them in the same cycle.
  assign bus.a_addr = (state_q == ST_LOAD && cnt_q < CW'(NWORDS)) ? cnt_q[AW-1:0] : '0;
  assign bus.b_addr = (state_q == ST_LOAD && mode_q == MULTIPLY && cnt_q < CW'(NWORDS))
                      ? cnt_q[AW-1:0] : '0;
  assign bus.d_wren = (state_q == ST_STORE);
  assign bus.d_addr = (state_q == ST_STORE) ? cnt_q[AW-1:0] : '0;
  assign bus.d_dout = (state_q == ST_STORE) ? r_q[WORD_W-1:0] : '0;
  assign bus.rdy    = (state_q == ST_DONE);

endmodule

// File: tb/tb_p256_mod_mul.sv
// Directed scoreboard bench for p256_mod_mul (NWORDS=8, P-256 modulus).
module tb_p256_mod_mul;
  import p256_pkg::*;

  localparam int NW = 8;
  localparam int AW = 3;
  localparam logic [255:0] P = P256_P;
`ifdef P256_MOD_MUL_INPUT_REDUCE_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = 2 * NW + 256 + 2 + EXTRA;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  p256_mod_mul_if #(.AW(AW)) bus_if ();

  p256_mod_mul #(.NWORDS(NW), .MODULUS(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  logic [31:0] a_mem [NW];
  logic [31:0] b_mem [NW];

  // Synchronous RAMs with one-cycle read latency.
  always @(posedge clk) begin
    bus_if.a_din <= a_mem[bus_if.a_addr];
    bus_if.b_din <= b_mem[bus_if.b_addr];
  end

  wr_t sb[$];
  int  rdy_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc, nwr, first_wr, last_wr;
  logic b_touched, addr_seq_ok;

  function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    prod = {256'd0, a} * {256'd0, b};
    return 256'(prod % {256'd0, P});
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_ops(input logic [255:0] a, input logic [255:0] b, input logic sq);
    for (int i = 0; i < NW; i++) begin
      a_mem[i] = a[32*i +: 32];
      b_mem[i] = sq ? $urandom : b[32*i +: 32];
    end
  endtask

  task automatic push_exp(input logic [255:0] r);
    for (int i = 0; i < NW; i++) sb.push_back('{addr: 3'(i), data: r[32*i +: 32]});
  endtask

  task automatic clear_stats();
    nwr = 0; first_wr = -1; last_wr = -1;
    rdy_q.delete();
    b_touched = 1'b0; addr_seq_ok = 1'b1;
  endtask

  // Called once per cycle at the falling edge.
  task automatic observe(input logic b_used);
    wr_t e;
    if (bus_if.d_wren) begin
      nwr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      check("write_expected", 256'(sb.size() != 0), 256'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("d_addr", 256'(bus_if.d_addr), 256'(e.addr));
        check("d_dout", 256'(bus_if.d_dout), 256'(e.data));
      end
    end
    if (bus_if.rdy) rdy_q.push_back(cyc);
    if (!b_used && bus_if.b_addr != '0) b_touched = 1'b1;
    if (cyc >= 1 && cyc <= NW) begin
      if (bus_if.a_addr != 3'(cyc - 1)) addr_seq_ok = 1'b0;
      if (b_used && bus_if.b_addr != 3'(cyc - 1)) addr_seq_ok = 1'b0;
    end
  endtask

  task automatic start_op(input logic m, input logic [255:0] a, input logic [255:0] b);
    clear_stats();
    load_ops(a, b, !m);
    push_exp(model(a, m ? b : a));
    @(negedge clk);
    bus_if.ena  = 1'b1;
    bus_if.mode = m;
    cyc = 0;
  endtask

  task automatic do_op(input logic m, input logic [255:0] a, input logic [255:0] b,
                       input string tag);
    int r0;
    start_op(m, a, b);
    while (rdy_q.size() == 0 && cyc < LAT + 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus_if.ena  = 1'b0;
        bus_if.mode = ~m;
      end
      observe(m);
    end
    r0 = (rdy_q.size() != 0) ? rdy_q[0] : -1;
    check({tag, "_latency"}, 256'(r0), 256'(LAT));
    check({tag, "_nwrites"}, 256'(nwr), 256'(NW));
    check({tag, "_first_wr"}, 256'(first_wr), 256'(LAT - NW));
    check({tag, "_last_wr"}, 256'(last_wr), 256'(LAT - 1));
    check({tag, "_sb_empty"}, 256'(sb.size()), 256'd0);
    check({tag, "_addr_seq"}, 256'(addr_seq_ok), 256'd1);
    if (!m) check({tag, "_b_untouched"}, 256'(b_touched), 256'd0);
    @(negedge clk);
    cyc++;
    check({tag, "_rdy_pulse"}, 256'(bus_if.rdy), 256'd0);
  endtask

  task automatic abort_at(input int at_cyc, input string tag);
    logic wren_seen;
    start_op(1'b0, 256'h1234_5678_9abc_def0, 256'd0);
    while (cyc < at_cyc) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus_if.ena = 1'b0;
      observe(1'b0);
    end
    rst = 1'b1;
    #1;
    check({tag, "_outputs_zero"},
          256'({bus_if.d_wren, bus_if.rdy, bus_if.d_addr, bus_if.a_addr,
                bus_if.b_addr, bus_if.d_dout}), 256'd0);
    wren_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.d_wren) wren_seen = 1'b1;
    end
    check({tag, "_no_wren"}, 256'(wren_seen), 256'd0);
    sb.delete();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] gx, ra, rb;
    int r0, r1;
    gx = 256'h6b17d1f2e12c4247f8bce6e563a440f277037d812deb33a0f4a13945d898c296;
    bus_if.ena  = 1'b0;
    bus_if.mode = 1'b0;
    for (int i = 0; i < NW; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end

    repeat (3) @(negedge clk);
    check("reset_outputs",
          256'({bus_if.d_wren, bus_if.rdy, bus_if.d_addr, bus_if.a_addr,
                bus_if.b_addr, bus_if.d_dout}), 256'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, gx, 256'd0, "sq_gx");
    do_op(1'b1, 256'd2, P - 256'd1, "mul_2_pm1");
    do_op(1'b0, P - 256'd1, 256'd0, "sq_pm1");
    do_op(1'b0, 256'd0, 256'd0, "sq_zero");
    do_op(1'b1, 256'd1, 256'd5, "mul_1_5");

    abort_at(NW + 2 + EXTRA + 100, "rst_mul");
    do_op(1'b0, 256'd3, 256'd0, "sq_3_after_rst");

    abort_at(LAT - 5, "rst_store");
    for (int i = 0; i < NW; i++) begin
      ra[32*i +: 32] = $urandom;
      rb[32*i +: 32] = $urandom;
    end
    ra[255] = 1'b0;
    rb[255] = 1'b0;
    do_op(1'b1, ra, rb, "mul_rand");

    // ena held across two operations; mode toggles mid-operation are ignored.
    clear_stats();
    load_ops(256'd1, 256'd5, 1'b0);
    push_exp(256'd5);
    @(negedge clk);
    bus_if.ena  = 1'b1;
    bus_if.mode = 1'b1;
    cyc = 0;
    while (rdy_q.size() < 2 && cyc < 2 * LAT + 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3)       bus_if.mode = 1'b0;
      if (cyc == 20)      load_ops(256'd7, 256'd0, 1'b1);
      if (cyc == LAT + 1) push_exp(256'd49);
      if (cyc == LAT + 6) begin
        bus_if.ena  = 1'b0;
        bus_if.mode = 1'b1;
      end
      observe(cyc <= LAT);
    end
    r0 = (rdy_q.size() > 0) ? rdy_q[0] : -1;
    r1 = (rdy_q.size() > 1) ? rdy_q[1] : -1;
    check("hold_rdy1", 256'(r0), 256'(LAT));
    check("hold_rdy2", 256'(r1), 256'(2 * LAT + 1));
    check("hold_nwrites", 256'(nwr), 256'(2 * NW));
    check("hold_sb_empty", 256'(sb.size()), 256'd0);
    check("hold_b_untouched", 256'(b_touched), 256'd0);
    repeat (3) @(negedge clk);

`ifdef P256_MOD_MUL_INPUT_REDUCE_EN
    do_op(1'b1, P + 256'd3, 256'd1, "mul_unreduced");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/p256_mod_mul.md
# p256_mod_mul

Word-serial modular multiplier over a parametrised prime field; the generalised successor to the fixed P-256 squaring unit. Reads operands word by word from synchronous RAM, computes A·B mod MODULUS (or A² mod MODULUS) with interleaved shift-add/conditional-subtract, and writes the result back word by word. It sits between the operand RAMs and the point-arithmetic sequencer, started by `ena` and acknowledged by `rdy`.

## Interface
- `NWORDS`, 8: operand length in 32-bit words; W = 32·NWORDS.
- `MODULUS`, 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff: W-bit odd prime, with MSB set.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `ena` input 1: start request, sampled only in IDLE.
- `mode` input 1: 0 = square (B := A), 1 = multiply; sampled with `ena`.
- `a_din` input 32: A word, valid one cycle after `a_addr`.
- `b_din` input 32: B word, valid one cycle after `b_addr`; ignored in square mode.
- `a_addr` output $clog2(NWORDS): A read address.
- `b_addr` output $clog2(NWORDS): B read address.
- `d_addr` output $clog2(NWORDS): result write address.
- `d_wren` output 1: result write strobe.
- `d_dout` output 32: result word.
- `rdy` output 1: one-cycle completion pulse.

## Operation
- Word order: address 0 holds the least significant word.
- States: IDLE → LOAD → (RED_IN) → MUL → STORE → DONE → IDLE.
- IDLE: all outputs are 0. `ena`=1 latches `mode`, clears the word counter, and moves to LOAD.
- LOAD: NWORDS+1 cycles. `a_addr`/`b_addr` = k on load cycle k (0..NWORDS-1). Word k is captured on cycle k+1. In square mode the B register is loaded from `a_din`.
- RED_IN (macro only): see Configuration.
- MUL: W cycles, scanning B from bit W-1 down to 0. Each cycle: T = 2R + b_i·A (W+2 bits); R' = T − P·n with n∈{0,1,2}, the largest n keeping R' ≥ 0. R starts at 0. Invariant R < P.
- STORE: NWORDS cycles. `d_wren`=1, `d_addr`=k, `d_dout`=R[32k+31:32k] for k = 0..NWORDS-1.
- DONE: `rdy`=1 for one cycle, then IDLE.
- Input precondition without the macro: A, B < MODULUS. If it is violated, the result is unspecified, but the state sequence and latency are unchanged.
- `ena` and `mode` are ignored outside IDLE. If `ena` is still high in the IDLE cycle after DONE, a new operation starts.
- `rst` asserted in any state: immediately go to IDLE. All outputs are 0, R/A/B and counters are cleared, and no partial write completes after reset asserts.

## Timing
- Cycle 0 is the edge sampling `ena` in IDLE.
- LOAD occupies cycles 1..NWORDS+1. MUL follows for W cycles, then STORE for NWORDS cycles, then DONE for 1 cycle.
- Latency from `ena` sample to `rdy` high: 2·NWORDS + W + 2 cycles. For NWORDS=8 this is 274; add 2 with the macro.
- `d_wren` is high for exactly NWORDS consecutive cycles, immediately before `rdy`.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- The RAM read latency is exactly 1 cycle; the block makes no other assumption about the RAM.

## Configuration
- `P256_MOD_MUL_INPUT_REDUCE_EN` defined: RED_IN state of 2 cycles after LOAD. Cycle 1 does A := A−P if A ≥ P. Cycle 2 does B := B−P if B ≥ P (B := reduced A in square mode). Inputs < 2·MODULUS then give correct results.
- Not defined: RED_IN is absent. LOAD goes directly to MUL.

## Structure
- Package `p256_pkg` holds:
  - `WORD_W` = 32
  - default `NWORDS` and the P-256 modulus constant `P256_P`
  - the `state_t` enum (IDLE, LOAD, RED_IN, MUL, STORE, DONE)
  - the `mode_t` enum (SQUARE, MULTIPLY)
- Sub-module `p256_mod_mul_step`: combinational single MUL iteration. Inputs R, A, bit, MODULUS; output R'. Parametrised by W.

## Test plan
- Square Gx=6b17d1f2…d898c296, NWORDS=8 -> 8 writes equal (Gx·Gx) mod P from the TB model; `rdy` at cycle 274.
- Multiply A=2, B=P−1 -> result P−2; square A=P−1 -> result 1; A=0 -> result 0.
- Multiply A=1, B=5 -> 5. Check that `b_addr` sequences 0..7 and that the B RAM is never read in square mode with B RAM preloaded with garbage.
- Assert `rst` at MUL cycle 100 -> all outputs 0 the same cycle and no `d_wren`. A following square of 3 gives 9 with full latency.
- Hold `ena` high across two operations -> second starts in the IDLE cycle after `rdy`, and `mode` changes mid-operation are ignored.
- With `P256_MOD_MUL_INPUT_REDUCE_EN`: multiply A=P+3, B=1 -> result 3, latency 276.
